ntt_bram_stream_reader: RTL and testbench

//  Read-side master for the NTT kernel's 128x128 coefficient BRAM (byte-addressed, 1-cycle read latency,
//  Do gated by EN). On a start pulse, reads LEN consecutive words from BASE (wrapping mod WL) and streams

---
 rtl/ntt_bram_stream_reader_if.sv | 36 +++
 rtl/ntt_bram_stream_reader.sv | 151 +++++++++++++++
 tb/tb_ntt_bram_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bram_stream_reader_if.sv
// Purpose: control, BRAM read port and AXI-Stream master bundle for the NTT BRAM stream reader.
// Latency: none, wires only.
// Backpressure: carries m_tready from the sink back to the reader.
interface ntt_bram_stream_reader_if #(
    parameter int DW = 128,
    parameter int LW = 7,
    parameter int AW = 13
);
    logic          start;
    logic [LW-1:0] base_word;
    logic [LW:0]   len;
    logic          busy;
    logic          done;

    logic          bram_EN;
    logic [3:0]    bram_WE;
    logic [AW-1:0] bram_A;
    logic [DW-1:0] bram_Do;

    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    // Reader side: drives BRAM address/enable and the stream.
    modport master (
        input  start, base_word, len, bram_Do, m_tready,
        output busy, done, bram_EN, bram_WE, bram_A, m_tdata, m_tvalid, m_tlast
    );

    // Environment side: issues commands, models the BRAM, consumes the stream.
    modport slave (
        output start, base_word, len, bram_Do, m_tready,
        input  busy, done, bram_EN, bram_WE, bram_A, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/ntt_bram_stream_reader.sv
// Purpose: streams LEN consecutive BRAM words from BASE (wrapping) out as an AXI-Stream burst with TLAST.
// Latency: start at t -> first read issued t+1 -> word captured t+2 -> m_tvalid at t+3; 1 beat/cycle sustained.
// Backpressure: 2-entry output FIFO with read credits; reads stop when FIFO plus in-flight read would exceed 2.
module ntt_bram_stream_reader #(
    parameter int DW = 128,
    parameter int WL = 128,
    parameter int AW = 13
) (
    input logic                      CLK,
    input logic                      RST,
    ntt_bram_stream_reader_if.master bus
);
    localparam int LW = $clog2(WL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [LW-1:0] base_q;
    logic [LW:0]   len_q;
    logic [LW:0]   issued;
    logic [LW:0]   beat_cnt;
    logic          inflight;
    logic [DW-1:0] fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;
    logic          en_q;
    logic          done_q;

    logic          start_acc;
    logic          start_run;
    logic          start_zero;
    logic          tvalid_int;
    logic          tlast_int;
    logic          pop;
    logic          last_pop;
    logic          issue;
    logic          last_issue;
    logic [2:0]    credit_use;
    logic [LW-1:0] idx;

    // Word index of the next read; LW-bit add gives the wrap modulo WL for free.
    assign idx = base_q + issued[LW-1:0];

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: RUN while reads remain to issue, DRAIN until the last beat leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_run)  state_nxt = S_RUN;
            S_RUN:   if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (last_pop)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-cycle control: start acceptance, stream handshake and credit-gated read issue.
    always_comb begin
        start_acc  = (state == S_IDLE) && bus.start;
        start_run  = start_acc && (bus.len != '0);
        start_zero = start_acc && (bus.len == '0);
        tvalid_int = (occ != 2'd0);
        tlast_int  = tvalid_int && (beat_cnt == (len_q - 1'b1));
        pop        = tvalid_int && bus.m_tready;
        last_pop   = pop && tlast_int;
        credit_use = {1'b0, occ} + {2'b00, inflight};
        // A pop this cycle frees a slot in time for the word this read returns.
        issue      = (state == S_RUN) && (issued < len_q) &&
                     ((credit_use < 3'd2) || ((credit_use == 3'd2) && pop));
        last_issue = issue && ((issued + 1'b1) == len_q);
    end

    // Transfer parameters and issue/beat counters, loaded on an accepted non-empty start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            beat_cnt <= '0;
        end else if (start_run) begin
            base_q   <= bus.base_word;
            len_q    <= bus.len;
            issued   <= '0;
            beat_cnt <= '0;
        end else begin
            if (issue) issued   <= issued + 1'b1;
            if (pop)   beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Read pipeline and 2-entry output FIFO; Do is captured the cycle after its address issued.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                fifo_mem[wr_ptr] <= bus.bram_Do;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // BRAM enable held through RUN, DRAIN and the done cycle so every capture sees live Do; done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= (state_nxt != S_IDLE) || ((state == S_DRAIN) && last_pop);
            done_q <= ((state == S_DRAIN) && last_pop) || start_zero;
        end
    end

    // Output drive: read-only BRAM port, stream from FIFO head, status from state.
    always_comb begin
        bus.busy     = (state != S_IDLE);
        bus.done     = done_q;
        bus.bram_EN  = en_q;
        bus.bram_WE  = 4'b0000;
        bus.bram_A   = {{(AW-LW-2){1'b0}}, idx, 2'b00};
        bus.m_tdata  = fifo_mem[rd_ptr];
        bus.m_tvalid = tvalid_int;
        bus.m_tlast  = tlast_int;
    end
endmodule

// File: tb/tb_ntt_bram_stream_reader.sv
// Purpose: directed self-checking bench for ntt_bram_stream_reader against a RAM[i]=i BRAM model.
// Latency: checks first beat at start+3 and done one cycle after the final handshake.
// Backpressure: exercises toggling ready, a long stall, back-to-back starts and mid-transfer reset.
module tb_ntt_bram_stream_reader;
    localparam int DW  = 128;
    localparam int WL  = 128;
    localparam int LW  = 7;
    localparam int LW1 = LW + 1;
    localparam int AW  = 13;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    ntt_bram_stream_reader_if #(.DW(DW), .LW(LW), .AW(AW)) bus();

    ntt_bram_stream_reader #(.DW(DW), .WL(WL), .AW(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // BRAM model: 1-cycle latency, Do only updates while EN is high.
    logic [DW-1:0] ram [WL];
    logic [DW-1:0] do_r;
    initial begin
        for (int i = 0; i < WL; i++) ram[i] = DW'(i);
        do_r = '0;
    end
    always @(posedge CLK) if (bus.bram_EN) do_r <= ram[bus.bram_A[LW+1:2]];
    assign bus.bram_Do = do_r;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_dat [$];
    logic          got_last [$];
    int            got_cyc [$];
    logic [AW-1:0] addr_log [$];
    int            first_valid;
    int            done_cyc;
    int            hold_viol;
    int            we_viol;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input int b, input int l);
        bus.start     = 1'b1;
        bus.base_word = LW'(b);
        bus.len       = LW1'(l);
        @(negedge CLK);
        bus.start     = 1'b0;
    endtask

    // Records beats/addresses cycle by cycle (c relative to the start cycle) until done or budget.
    task automatic collect(input int mode, input int c0, input int max_cyc);
        logic [DW-1:0] held;
        logic          held_last;
        bit            stalled;
        got_dat.delete(); got_last.delete(); got_cyc.delete(); addr_log.delete();
        first_valid = -1; done_cyc = -1; hold_viol = 0; we_viol = 0;
        stalled = 1'b0; held = '0; held_last = 1'b0;
        for (int c = c0; c <= max_cyc; c++) begin
            if (mode == 1) bus.m_tready = c[0];
            else           bus.m_tready = 1'b1;
            addr_log.push_back(bus.bram_A);
            if (bus.bram_WE !== 4'b0000) we_viol++;
            if (bus.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (bus.m_tvalid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                if (stalled && (bus.m_tdata !== held || bus.m_tlast !== held_last)) hold_viol++;
                if (bus.m_tready) begin
                    got_dat.push_back(bus.m_tdata);
                    got_last.push_back(bus.m_tlast);
                    got_cyc.push_back(c);
                    stalled = 1'b0;
                end else begin
                    held      = bus.m_tdata;
                    held_last = bus.m_tlast;
                    stalled   = 1'b1;
                end
            end else if (stalled) begin
                hold_viol++;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (bus.busy     !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done     !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.bram_EN  !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.bram_EN); end
        checks++; if (bus.bram_WE  !== 4'b0) begin errors++; $display("FAIL reset_we: got %h expected 0", bus.bram_WE); end
        checks++; if (bus.bram_A   !== '0)   begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.bram_A); end
        checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_tvalid); end
        checks++; if (bus.m_tlast  !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", bus.m_tlast); end
        checks++; if (bus.m_tdata  !== '0)   begin errors++; $display("FAIL reset_tdata: got %h expected 0", bus.m_tdata); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        int bad;
        bus.m_tready = 1'b1;
        pulse_start(0, 4);
        checks++; if (bus.busy !== 1'b1 || bus.bram_EN !== 1'b1 || bus.bram_A !== 13'h000) begin
            errors++; $display("FAIL basic_issue1: busy=%b en=%b addr=%h expected 1 1 000", bus.busy, bus.bram_EN, bus.bram_A); end
        collect(0, 1, 40);
        checks++; if (first_valid !== 3) begin errors++; $display("FAIL basic_first_valid: got %0d expected 3", first_valid); end
        bad = 0;
        if (got_dat.size() != 4) bad++;
        else for (int i = 0; i < 4; i++)
            if (got_dat[i] !== DW'(i) || got_cyc[i] != 3 + i || got_last[i] !== (i == 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_beats: %0d beats, %0d wrong, expected 4 beats 0..3 at cycles 3..6", got_dat.size(), bad); end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
        checks++; if (bus.busy !== 1'b0 || bus.bram_EN !== 1'b1) begin
            errors++; $display("FAIL basic_done_state: busy=%b en=%b expected 0 1", bus.busy, bus.bram_EN); end
        @(negedge CLK);
        checks++; if (bus.bram_EN !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL basic_after_done: en=%b done=%b expected 0 0", bus.bram_EN, bus.done); end
    endtask

    task automatic test_wrap();
        int bad;
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 13'h1F8; exp_a[1] = 13'h1FC; exp_a[2] = 13'h000; exp_a[3] = 13'h004;
        pulse_start(126, 4);
        collect(0, 1, 40);
        bad = 0;
        if (addr_log.size() < 4) bad++;
        else for (int i = 0; i < 4; i++) if (addr_log[i] !== exp_a[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_addr: %0d wrong, first=%h expected 1F8,1FC,000,004", bad, addr_log.size() > 0 ? addr_log[0] : 13'h0); end
        bad = 0;
        if (got_dat.size() != 4) bad++;
        else for (int i = 0; i < 4; i++) if (got_dat[i] !== DW'((126 + i) % WL) || got_last[i] !== (i == 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_beats: %0d beats, %0d wrong, expected 126,127,0,1", got_dat.size(), bad); end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 7", done_cyc); end
        @(negedge CLK);
    endtask

    task automatic test_full_toggle();
        int bad;
        int nlast;
        pulse_start(0, 128);
        collect(1, 1, 600);
        bad = 0; nlast = 0;
        for (int i = 0; i < got_dat.size(); i++) begin
            if (got_dat[i] !== DW'(i)) bad++;
            if (got_last[i] === 1'b1) nlast++;
        end
        checks++; if (got_dat.size() != 128) begin errors++; $display("FAIL full_count: got %0d expected 128", got_dat.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_order: %0d wrong beats expected 0", bad); end
        checks++; if (nlast !== 1 || got_last.size() != 128 || got_last[127] !== 1'b1) begin
            errors++; $display("FAIL full_tlast: %0d tlast beats expected 1 on beat 127", nlast); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL full_hold: got %0d violations expected 0", hold_viol); end
        checks++; if (we_viol !== 0) begin errors++; $display("FAIL full_we: got %0d nonzero WE cycles expected 0", we_viol); end
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL full_done: got %0d expected a done cycle", done_cyc); end
        @(negedge CLK);
    endtask

    task automatic test_stall();
        int bad;
        pulse_start(0, 8);
        bus.m_tready = 1'b0;
        repeat (9) @(negedge CLK);
        checks++; if (bus.bram_A !== 13'h008) begin errors++; $display("FAIL stall_reads: addr=%h expected 008 (2 reads)", bus.bram_A); end
        checks++; if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== '0) begin
            errors++; $display("FAIL stall_head: tvalid=%b tdata=%h expected 1 0", bus.m_tvalid, bus.m_tdata); end
        collect(0, 10, 80);
        bad = 0;
        if (got_dat.size() != 8) bad++;
        else for (int i = 0; i < 8; i++) if (got_dat[i] !== DW'(i) || got_last[i] !== (i == 7)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_beats: %0d beats, %0d wrong, expected 0..7", got_dat.size(), bad); end
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL stall_done: got %0d expected a done cycle", done_cyc); end
        @(negedge CLK);
    endtask

    task automatic test_len0();
        pulse_start(9, 0);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL len0_done: done=%b busy=%b expected 1 0", bus.done, bus.busy); end
        checks++; if (bus.bram_EN !== 1'b0 || bus.m_tvalid !== 1'b0) begin
            errors++; $display("FAIL len0_idle: en=%b tvalid=%b expected 0 0", bus.bram_EN, bus.m_tvalid); end
        @(negedge CLK);
        checks++; if (bus.done !== 1'b0 || bus.bram_EN !== 1'b0) begin
            errors++; $display("FAIL len0_after: done=%b en=%b expected 0 0", bus.done, bus.bram_EN); end
    endtask

    task automatic test_busy_ignore();
        int bad;
        pulse_start(10, 4);
        bus.start = 1'b1; bus.base_word = LW'(50); bus.len = LW1'(2);
        @(negedge CLK);
        bus.start = 1'b0;
        collect(0, 2, 40);
        bad = 0;
        if (got_dat.size() != 4) bad++;
        else for (int i = 0; i < 4; i++) if (got_dat[i] !== DW'(10 + i) || got_last[i] !== (i == 3)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL busy_ignore_beats: %0d beats, %0d wrong, expected 10..13", got_dat.size(), bad); end
        checks++; if (done_cyc !== 7) begin errors++; $display("FAIL busy_ignore_done: got %0d expected 7", done_cyc); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (bus.m_tvalid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL busy_ignore_quiet: %0d active cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        int bad;
        pulse_start(20, 2);
        collect(0, 1, 40);
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL b2b_first_done: got %0d expected 5", done_cyc); end
        pulse_start(30, 3);
        checks++; if (bus.bram_EN !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: en=%b busy=%b expected 1 1", bus.bram_EN, bus.busy); end
        collect(0, 1, 40);
        bad = 0;
        if (got_dat.size() != 3) bad++;
        else for (int i = 0; i < 3; i++) if (got_dat[i] !== DW'(30 + i) || got_last[i] !== (i == 2)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_beats: %0d beats, %0d wrong, expected 30..32", got_dat.size(), bad); end
        checks++; if (first_valid !== 3 || done_cyc !== 6) begin
            errors++; $display("FAIL b2b_timing: first=%0d done=%0d expected 3 6", first_valid, done_cyc); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int bad;
        bus.m_tready = 1'b1;
        pulse_start(0, 16);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bram_EN !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: busy=%b done=%b en=%b expected 0 0 0", bus.busy, bus.done, bus.bram_EN); end
        checks++; if (bus.bram_A !== '0 || bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0 || bus.m_tdata !== '0) begin
            errors++; $display("FAIL rstmid_data: addr=%h tvalid=%b tlast=%b tdata=%h expected all 0", bus.bram_A, bus.m_tvalid, bus.m_tlast, bus.m_tdata); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (bus.done !== 1'b0 || bus.m_tvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_quiet: done=%b tvalid=%b expected 0 0", bus.done, bus.m_tvalid); end
        pulse_start(5, 2);
        collect(0, 1, 40);
        bad = 0;
        if (got_dat.size() != 2) bad++;
        else for (int i = 0; i < 2; i++) if (got_dat[i] !== DW'(5 + i) || got_last[i] !== (i == 1)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_beats: %0d beats, %0d wrong, expected 5,6", got_dat.size(), bad); end
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL rstmid_done: got %0d expected 5", done_cyc); end
        @(negedge CLK);
    endtask

    initial begin
        RST           = 1'b1;
        bus.start     = 1'b0;
        bus.base_word = '0;
        bus.len       = '0;
        bus.m_tready  = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_full_toggle();
        test_stall();
        test_len0();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
